// File: rtl/regfile_sp_if.sv
// Bus bundle for the regfile_sp register file: write port, two read ports,
// stack-pointer controls and bulk-clear handshake.
interface regfile_sp_if #(
   parameter int WIDTH = 8,
   parameter int AW    = 5
);
   logic             we;
   logic [AW-1:0]    waddr;
   logic [WIDTH-1:0] wdata;
   logic [AW-1:0]    raddr_a;
   logic [WIDTH-1:0] rdata_a;
   logic [AW-1:0]    raddr_b;
   logic [WIDTH-1:0] rdata_b;
   logic             sp_inc;
   logic             sp_dec;
   logic [WIDTH-1:0] sp;
   logic             clr_start;
   logic             busy;

   modport master (
      output we, waddr, wdata, raddr_a, raddr_b, sp_inc, sp_dec, clr_start,
      input  rdata_a, rdata_b, sp, busy
   );

   modport slave (
      input  we, waddr, wdata, raddr_a, raddr_b, sp_inc, sp_dec, clr_start,
      output rdata_a, rdata_b, sp, busy
   );
endinterface

// File: rtl/regfile_sp.sv
// Multi-port register file with write-through bypass, a hardware stack-pointer
// register and a sequenced bulk-clear engine.
module regfile_sp #(
   parameter int               WIDTH  = 8,
   parameter int               DEPTH  = 32,
   parameter int               AW     = 5,
   parameter int               SP_IDX = 29,
   parameter logic [WIDTH-1:0] SP_RST = {WIDTH{1'b1}}
) (
   input  logic         clk,
   input  logic         rst_n,
   regfile_sp_if.slave  bus
);

   localparam logic [AW:0]   DEPTH_L  = (AW+1)'(DEPTH);
   localparam logic [AW-1:0] SP_ADDR  = AW'(SP_IDX);
   localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } state_t;

   state_t           state_r;
   state_t           state_nxt_s;
   logic [AW-1:0]    ptr_r;
   logic [WIDTH-1:0] regs_r [DEPTH];

   logic             busy_s;
   logic             clr_load_s;
   logic             wr_acc_s;
   logic             wr_sp_s;
   logic             sp_op_s;
   logic [WIDTH-1:0] sp_nxt_s;
   logic [WIDTH-1:0] rdata_a_s;
   logic [WIDTH-1:0] rdata_b_s;

   function automatic logic [WIDTH-1:0] rst_val(input int idx);
      return (idx == SP_IDX) ? SP_RST : {WIDTH{1'b0}};
   endfunction

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // FSM next-state logic
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (bus.clr_start) begin
               state_nxt_s = ST_CLEAR;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_CLEAR: begin
            if (ptr_r == LAST_PTR) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_CLEAR;
            end
         end
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // FSM output decode
   always_comb begin
      busy_s     = 1'b0;
      clr_load_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            busy_s     = 1'b0;
            clr_load_s = bus.clr_start;
         end
         ST_CLEAR: begin
            busy_s     = 1'b1;
            clr_load_s = 1'b0;
         end
         default: begin
            busy_s     = 1'b0;
            clr_load_s = 1'b0;
         end
      endcase
   end

   // clear sweep pointer
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_r <= {AW{1'b0}};
      end else if (clr_load_s) begin
         ptr_r <= {AW{1'b0}};
      end else if (busy_s) begin
         ptr_r <= ptr_r + AW'(1);
      end else begin
         ptr_r <= ptr_r;
      end
   end

   // write / SP-op acceptance; a write to SP wins over inc/dec
   always_comb begin
      wr_acc_s = !busy_s && bus.we && ({1'b0, bus.waddr} < DEPTH_L);
      wr_sp_s  = wr_acc_s && (bus.waddr == SP_ADDR);
      sp_op_s  = !busy_s && (bus.sp_inc ^ bus.sp_dec) && !wr_sp_s;
      if (bus.sp_inc) begin
         sp_nxt_s = regs_r[SP_IDX] + WIDTH'(1);
      end else begin
         sp_nxt_s = regs_r[SP_IDX] - WIDTH'(1);
      end
   end

   // register array: reset, clear sweep, write port, SP update
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs_r[i] <= rst_val(i);
         end
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (busy_s) begin
               if (ptr_r == AW'(i)) begin
                  regs_r[i] <= rst_val(i);
               end
            end else if (wr_acc_s && (bus.waddr == AW'(i))) begin
               regs_r[i] <= bus.wdata;
            end else if ((i == SP_IDX) && sp_op_s) begin
               regs_r[i] <= sp_nxt_s;
            end
         end
      end
   end

   // read ports; out-of-range addresses fall through to zero
   always_comb begin
      rdata_a_s = {WIDTH{1'b0}};
      rdata_b_s = {WIDTH{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
         rdata_a_s = (bus.raddr_a == AW'(i)) ? regs_r[i] : rdata_a_s;
         rdata_b_s = (bus.raddr_b == AW'(i)) ? regs_r[i] : rdata_b_s;
      end
      rdata_a_s = (wr_acc_s && (bus.waddr == bus.raddr_a)) ? bus.wdata : rdata_a_s;
      rdata_b_s = (wr_acc_s && (bus.waddr == bus.raddr_b)) ? bus.wdata : rdata_b_s;
   end

   assign bus.rdata_a = rdata_a_s;
   assign bus.rdata_b = rdata_b_s;
   assign bus.sp      = regs_r[SP_IDX];
   assign bus.busy    = busy_s;

endmodule

// File: tb/tb_regfile_sp.sv
// Self-checking bench for regfile_sp: default instance and a 16x24 variant,
// checked every cycle against a behavioural model plus literal expectations.
module tb_regfile_sp;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   regfile_sp_if #(.WIDTH(8),  .AW(5)) bus0 ();
   regfile_sp_if #(.WIDTH(16), .AW(5)) bus1 ();

   regfile_sp #(.WIDTH(8), .DEPTH(32), .AW(5), .SP_IDX(29), .SP_RST(8'hFF))
      dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
   regfile_sp #(.WIDTH(16), .DEPTH(24), .AW(5), .SP_IDX(23), .SP_RST(16'h0100))
      dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

   int n_checks = 0;
   int n_err    = 0;

   int          depth [2] = '{32, 24};
   int          spi   [2] = '{29, 23};
   logic [15:0] sprst [2] = '{16'h00FF, 16'h0100};
   logic [15:0] mask  [2] = '{16'h00FF, 16'hFFFF};
   logic [15:0] mem   [2][32];
   int          clr_left [2];
   int          clr_ptr  [2];

   typedef struct packed {
      logic        we;
      logic [4:0]  wa;
      logic [15:0] wd;
      logic [4:0]  ra;
      logic [4:0]  rb;
      logic        inc;
      logic        dec;
      logic        cs;
   } in_t;

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic in_t get_in(input int k);
      in_t s;
      if (k == 0) begin
         s.we = bus0.we; s.wa = bus0.waddr; s.wd = {8'h00, bus0.wdata};
         s.ra = bus0.raddr_a; s.rb = bus0.raddr_b;
         s.inc = bus0.sp_inc; s.dec = bus0.sp_dec; s.cs = bus0.clr_start;
      end else begin
         s.we = bus1.we; s.wa = bus1.waddr; s.wd = bus1.wdata;
         s.ra = bus1.raddr_a; s.rb = bus1.raddr_b;
         s.inc = bus1.sp_inc; s.dec = bus1.sp_dec; s.cs = bus1.clr_start;
      end
      return s;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         for (int a = 0; a < 32; a++) mem[k][a] = (a == spi[k]) ? sprst[k] : 16'h0000;
         clr_left[k] = 0;
         clr_ptr[k]  = 0;
      end
   endtask

   task automatic model_step(input int k);
      in_t         s;
      logic        acc;
      logic [15:0] nv;
      s = get_in(k);
      if (clr_left[k] > 0) begin
         mem[k][clr_ptr[k]] = (clr_ptr[k] == spi[k]) ? sprst[k] : 16'h0000;
         clr_ptr[k]++;
         clr_left[k]--;
      end else begin
         acc = s.we && (int'(s.wa) < depth[k]);
         if (acc) mem[k][s.wa] = s.wd & mask[k];
         if (!(acc && int'(s.wa) == spi[k]) && (s.inc != s.dec)) begin
            nv = mem[k][spi[k]] + (s.inc ? 16'h0001 : mask[k]);
            mem[k][spi[k]] = nv & mask[k];
         end
         if (s.cs) begin
            clr_left[k] = depth[k];
            clr_ptr[k]  = 0;
         end
      end
   endtask

   function automatic logic [15:0] exp_rd(input int k, input logic [4:0] ra, input in_t s);
      if (clr_left[k] == 0 && s.we && int'(s.wa) < depth[k] && s.wa == ra) return s.wd & mask[k];
      else if (int'(ra) < depth[k]) return mem[k][ra];
      else return 16'h0000;
   endfunction

   // behavioural model: async reset, otherwise one update per rising edge
   initial begin
      model_reset();
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) model_reset();
         else for (int k = 0; k < 2; k++) model_step(k);
      end
   end

   // every-cycle comparison of both instances against the model
   initial begin
      forever begin
         @(negedge clk);
         for (int k = 0; k < 2; k++) begin
            in_t         s;
            logic [15:0] ga, gb, gs;
            logic        gy;
            s = get_in(k);
            if (k == 0) begin
               ga = {8'h00, bus0.rdata_a}; gb = {8'h00, bus0.rdata_b};
               gs = {8'h00, bus0.sp}; gy = bus0.busy;
            end else begin
               ga = bus1.rdata_a; gb = bus1.rdata_b; gs = bus1.sp; gy = bus1.busy;
            end
            chk($sformatf("u%0d_rdata_a", k), ga, exp_rd(k, s.ra, s));
            chk($sformatf("u%0d_rdata_b", k), gb, exp_rd(k, s.rb, s));
            chk($sformatf("u%0d_sp", k), gs, mem[k][spi[k]]);
            chk($sformatf("u%0d_busy", k), {15'h0000, gy}, {15'h0000, clr_left[k] > 0});
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus0.we = 1'b0; bus0.waddr = 5'd0; bus0.wdata = 8'h00;
      bus0.raddr_a = 5'd0; bus0.raddr_b = 5'd0;
      bus0.sp_inc = 1'b0; bus0.sp_dec = 1'b0; bus0.clr_start = 1'b0;
      bus1.we = 1'b0; bus1.waddr = 5'd0; bus1.wdata = 16'h0000;
      bus1.raddr_a = 5'd0; bus1.raddr_b = 5'd0;
      bus1.sp_inc = 1'b0; bus1.sp_dec = 1'b0; bus1.clr_start = 1'b0;
   endtask

   initial begin
      int n;
      idle_inputs();
      #2 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      // reset defaults
      bus0.raddr_a = 5'd29; bus0.raddr_b = 5'd0; bus1.raddr_a = 5'd23;
      #1;
      chk("rst_rd29", {8'h00, bus0.rdata_a}, 16'h00FF);
      chk("rst_rd0", {8'h00, bus0.rdata_b}, 16'h0000);
      chk("rst_sp", {8'h00, bus0.sp}, 16'h00FF);
      chk("rst_busy", {15'h0000, bus0.busy}, 16'h0000);
      chk("u1_rst_sp", bus1.sp, 16'h0100);
      for (int a = 0; a < 32; a++) begin
         bus0.raddr_a = 5'(a); bus0.raddr_b = 5'(31 - a); bus1.raddr_a = 5'(a);
         #1;
         chk("rst_sweep", {8'h00, bus0.rdata_a}, (a == 29) ? 16'h00FF : 16'h0000);
         step();
      end

      // write with bypass, then readback through the array
      bus0.we = 1'b1; bus0.waddr = 5'd5; bus0.wdata = 8'hA5;
      bus0.raddr_a = 5'd5; bus0.raddr_b = 5'd5;
      #1;
      chk("bypass_a", {8'h00, bus0.rdata_a}, 16'h00A5);
      chk("bypass_b", {8'h00, bus0.rdata_b}, 16'h00A5);
      step();
      bus0.we = 1'b0;
      #1;
      chk("array_a", {8'h00, bus0.rdata_a}, 16'h00A5);
      chk("array_b", {8'h00, bus0.rdata_b}, 16'h00A5);

      // SP arithmetic
      bus0.sp_inc = 1'b1; step(); bus0.sp_inc = 1'b0;
      chk("sp_wrap", {8'h00, bus0.sp}, 16'h0000);
      bus0.sp_dec = 1'b1; step(); step(); bus0.sp_dec = 1'b0;
      chk("sp_dec2", {8'h00, bus0.sp}, 16'h00FE);
      bus0.sp_inc = 1'b1; bus0.sp_dec = 1'b1; step();
      bus0.sp_inc = 1'b0; bus0.sp_dec = 1'b0;
      chk("sp_both", {8'h00, bus0.sp}, 16'h00FE);
      bus0.we = 1'b1; bus0.waddr = 5'd29; bus0.wdata = 8'h40; bus0.sp_inc = 1'b1;
      step();
      bus0.we = 1'b0; bus0.sp_inc = 1'b0;
      chk("sp_wr_wins", {8'h00, bus0.sp}, 16'h0040);

      // bulk clear with dropped write / restart during busy
      for (int a = 0; a < 32; a++) begin
         bus0.we = 1'b1; bus0.waddr = 5'(a); bus0.wdata = 8'(a);
         step();
      end
      bus0.we = 1'b0;
      bus0.clr_start = 1'b1; step(); bus0.clr_start = 1'b0;
      n = 0;
      while (bus0.busy && n < 100) begin
         bus0.we = (n == 10); bus0.waddr = 5'd3; bus0.wdata = 8'h77;
         bus0.clr_start = (n == 10); bus0.sp_inc = (n == 10);
         step();
         n++;
      end
      bus0.we = 1'b0; bus0.clr_start = 1'b0; bus0.sp_inc = 1'b0;
      chk("clr_cycles", 16'(n), 16'd32);
      bus0.raddr_a = 5'd3; bus0.raddr_b = 5'd29;
      #1;
      chk("clr_rd3", {8'h00, bus0.rdata_a}, 16'h0000);
      chk("clr_rd29", {8'h00, bus0.rdata_b}, 16'h00FF);
      bus0.we = 1'b1; bus0.waddr = 5'd7; bus0.wdata = 8'h5A; bus0.raddr_a = 5'd7;
      step();
      bus0.we = 1'b0;
      #1;
      chk("post_clr_wr", {8'h00, bus0.rdata_a}, 16'h005A);

      // variant instance: out-of-range, SP reset/dec, clear length
      bus1.we = 1'b1; bus1.waddr = 5'd25; bus1.wdata = 16'hBEEF; bus1.raddr_a = 5'd25;
      #1;
      chk("u1_oor_bypass", bus1.rdata_a, 16'h0000);
      step();
      bus1.we = 1'b0;
      #1;
      chk("u1_oor_rd", bus1.rdata_a, 16'h0000);
      bus1.sp_dec = 1'b1; step(); bus1.sp_dec = 1'b0;
      chk("u1_sp_dec", bus1.sp, 16'h00FF);
      bus1.clr_start = 1'b1; step(); bus1.clr_start = 1'b0;
      n = 0;
      while (bus1.busy && n < 100) begin
         step();
         n++;
      end
      chk("u1_clr_cycles", 16'(n), 16'd24);
      chk("u1_sp_after_clr", bus1.sp, 16'h0100);

      // reset mid-clear
      for (int a = 0; a < 32; a++) begin
         bus0.we = 1'b1; bus0.waddr = 5'(a); bus0.wdata = 8'(a + 1);
         step();
      end
      bus0.we = 1'b0;
      bus0.clr_start = 1'b1; bus1.clr_start = 1'b1; step();
      bus0.clr_start = 1'b0; bus1.clr_start = 1'b0;
      repeat (10) step();
      bus0.raddr_a = 5'd20; bus0.raddr_b = 5'd29;
      #1 rst_n = 1'b0;
      #1;
      chk("rst_mid_busy0", {15'h0000, bus0.busy}, 16'h0000);
      chk("rst_mid_busy1", {15'h0000, bus1.busy}, 16'h0000);
      chk("rst_mid_rd20", {8'h00, bus0.rdata_a}, 16'h0000);
      chk("rst_mid_rd29", {8'h00, bus0.rdata_b}, 16'h00FF);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      // randomized traffic on both instances
      for (int c = 0; c < 3000; c++) begin
         bus0.we = 1'($urandom_range(0, 1)); bus0.waddr = 5'($urandom_range(0, 31));
         bus0.wdata = 8'($urandom);
         bus0.raddr_a = ($urandom_range(0, 2) == 0) ? bus0.waddr : 5'($urandom_range(0, 31));
         bus0.raddr_b = ($urandom_range(0, 3) == 0) ? 5'd29 : 5'($urandom_range(0, 31));
         bus0.sp_inc = ($urandom_range(0, 3) == 0); bus0.sp_dec = ($urandom_range(0, 3) == 0);
         bus0.clr_start = ($urandom_range(0, 59) == 0);
         bus1.we = 1'($urandom_range(0, 1)); bus1.waddr = 5'($urandom_range(0, 31));
         bus1.wdata = 16'($urandom);
         bus1.raddr_a = ($urandom_range(0, 2) == 0) ? bus1.waddr : 5'($urandom_range(0, 31));
         bus1.raddr_b = ($urandom_range(0, 3) == 0) ? 5'd23 : 5'($urandom_range(0, 31));
         bus1.sp_inc = ($urandom_range(0, 3) == 0); bus1.sp_dec = ($urandom_range(0, 3) == 0);
         bus1.clr_start = ($urandom_range(0, 59) == 0);
         step();
      end

      idle_inputs();
      step();
      step();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule

// File: doc/regfile_sp.md
# regfile_sp

Parametrised multi-port register file for the 8-bit datapath. It provides two combinational read ports, one clocked write port with same-cycle write-through bypass, and a dedicated stack-pointer register with hardware increment and decrement. A sequenced bulk-clear engine returns every register to its reset value without asserting reset. It sits between the decoder/ALU and the stack logic and supplies register operands and the current stack pointer each cycle.

## Interface
- WIDTH, 8, register width in bits
- DEPTH, 32, number of registers; must satisfy 2 <= DEPTH <= 2^AW
- AW, 5, address width in bits
- SP_IDX, 29, index of the stack-pointer register; must be less than DEPTH
- SP_RST, all ones (8'hFF at default WIDTH), reset and clear value of the SP register

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- we  in  1  write enable
- waddr  in  AW  write address
- wdata  in  WIDTH  write data
- raddr_a  in  AW  read address, port A
- rdata_a  out  WIDTH  read data, port A (combinational)
- raddr_b  in  AW  read address, port B
- rdata_b  out  WIDTH  read data, port B (combinational)
- sp_inc  in  1  increment SP register
- sp_dec  in  1  decrement SP register
- sp  out  WIDTH  current SP register contents (registered, no bypass)
- clr_start  in  1  start bulk clear
- busy  out  1  bulk clear in progress

## Operation
- Reset (rst_n low, asynchronous):
  - All registers are set to 0, except register SP_IDX, which is set to SP_RST.
  - The FSM goes to IDLE. The clear pointer is set to 0. busy = 0.
  - sp = SP_RST. rdata_a and rdata_b show the reset contents.
- Reads:
  - rdata_x = reg[raddr_x], combinational.
  - Address >= DEPTH reads 0.
  - Bypass: if a write is accepted this cycle (we=1, busy=0, waddr<DEPTH) and waddr==raddr_x, then rdata_x = wdata.
- Write: at a rising edge with we=1, busy=0 and waddr<DEPTH, reg[waddr] takes wdata. Out-of-range writes are ignored.
- SP ops (accepted only when busy=0):
  - sp_inc alone: reg[SP_IDX] + 1, modulo 2^WIDTH.
  - sp_dec alone: reg[SP_IDX] - 1, modulo 2^WIDTH.
  - sp_inc and sp_dec together: no change.
  - An accepted write to SP_IDX in the same cycle wins; the SP op is dropped.
- FSM states:
  - IDLE to CLEAR: on a rising edge with clr_start=1. The clear pointer is loaded with 0.
  - CLEAR: each edge writes reg[ptr] with 0 (SP_RST when ptr==SP_IDX), then ptr increments.
  - CLEAR to IDLE: on the edge that clears ptr==DEPTH-1.
- busy = 1 exactly while in CLEAR.
- During CLEAR:
  - we, sp_inc, sp_dec and clr_start are ignored and dropped, not queued.
  - Bypass is disabled.
  - Reads return the current, partially cleared contents.
- A write or SP op accepted on the same edge that starts CLEAR still takes effect. Its register is later overwritten by the sweep.

## Timing
- Read latency is 0 cycles (combinational). sp reflects an update after the updating edge.
- Write-to-read latency is 0 through the bypass, and 1 edge through the array.
- Clear:
  - clr_start is sampled at edge k. busy is high from after edge k until after edge k+DEPTH, i.e. DEPTH cycles.
  - reg[i] is cleared at edge k+1+i.
  - The first new write is accepted at edge k+DEPTH+1.
- rst_n asserted mid-clear aborts it immediately: full reset contents, IDLE, busy=0.
- rst_n deassertion must be synchronous to clk at system level; the block adds no synchronizer.

## Test plan
- Reset, defaults:
  - Stimulus: pulse rst_n low for 3 cycles.
  - Required: every address reads 0 except 29, which reads 8'hFF. sp=8'hFF, busy=0.
- Write, readback, bypass:
  - Stimulus: we=1, waddr=5, wdata=8'hA5, raddr_a=5, raddr_b=5.
  - Required: both rdata = 8'hA5 in the same cycle, and still 8'hA5 after the edge with we=0.
- SP arithmetic:
  - Stimulus: sp_inc for one cycle from reset.
    - Required: sp=8'h00 (wrap).
  - Stimulus: sp_dec twice.
    - Required: sp=8'hFE.
  - Stimulus: sp_inc and sp_dec together.
    - Required: sp unchanged.
  - Stimulus: we to address 29 with 8'h40, plus sp_inc.
    - Required: sp=8'h40.
- Bulk clear:
  - Stimulus: fill regs 0-31 with their index, pulse clr_start.
  - Required: busy high for exactly 32 cycles. A we to reg 3 during busy is dropped. At the end all regs are 0, reg 29 = 8'hFF, and a write on the next cycle is accepted.
- Reset mid-clear:
  - Stimulus: assert rst_n low 10 cycles into a clear.
  - Required: busy drops without waiting for a clock edge, and contents match the reset defaults.
- Parameter sweep:
  - Stimulus: WIDTH=16, DEPTH=24, SP_IDX=23, SP_RST=16'h0100.
  - Required: reads of addresses 24-31 return 0 and writes to them are ignored. sp resets to 16'h0100. sp_dec gives 16'h00FF. A clear takes 24 cycles.
